// File: rtl/dot_prod_accum.sv
// Streaming multiply-accumulate back end: sums a run of 8-bit products into an ACC_W-bit result.
// Define DOT_PROD_SAT_EN to saturate on overflow instead of wrapping.
module dot_prod_accum #(
    parameter int ACC_W = 12,
    parameter int LEN_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_start,
    input  logic [LEN_W-1:0] i_len,
    output logic             o_busy,
    input  logic [7:0]       i_p_data,
    input  logic             i_p_valid,
    output logic             o_p_ready,
    output logic [ACC_W-1:0] o_acc_out,
    output logic             o_out_valid,
    input  logic             i_out_ready,
    output logic             o_ovf
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ACC  = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t           r_state;
    logic [ACC_W-1:0] r_acc;
    logic [LEN_W-1:0] r_count;
    logic             r_ovf;
    logic             r_busy;
    logic             r_p_ready;
    logic             r_out_valid;

    logic [ACC_W:0]   w_sum;
    logic             w_carry;
    logic [ACC_W-1:0] w_acc_next;
    logic             w_accept;

    // One extra bit of headroom so the carry-out doubles as the overflow indication.
    assign w_sum   = {1'b0, r_acc} + {{(ACC_W + 1 - 8){1'b0}}, i_p_data};
    assign w_carry = w_sum[ACC_W];

`ifdef DOT_PROD_SAT_EN
    // Once at all-ones, any non-zero add carries again, so the value sticks for the run.
    assign w_acc_next = w_carry ? {ACC_W{1'b1}} : w_sum[ACC_W-1:0];
`else
    assign w_acc_next = w_sum[ACC_W-1:0];
`endif

    assign w_accept = i_p_valid & r_p_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_acc       <= '0;
            r_count     <= '0;
            r_ovf       <= 1'b0;
            r_busy      <= 1'b0;
            r_p_ready   <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_acc  <= '0;
                        r_ovf  <= 1'b0;
                        r_busy <= 1'b1;
                        if (i_len != '0) begin
                            r_count   <= i_len;
                            r_p_ready <= 1'b1;
                            r_state   <= S_ACC;
                        end else begin
                            r_out_valid <= 1'b1;
                            r_state     <= S_HOLD;
                        end
                    end
                end
                S_ACC: begin
                    if (w_accept) begin
                        r_acc   <= w_acc_next;
                        r_count <= r_count - LEN_W'(1);
                        if (w_carry) begin
                            r_ovf <= 1'b1;
                        end
                        if (r_count == LEN_W'(1)) begin
                            r_p_ready   <= 1'b0;
                            r_out_valid <= 1'b1;
                            r_state     <= S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    // A start arriving here is dropped; a new run must be requested from IDLE.
                    if (i_out_ready) begin
                        r_busy      <= 1'b0;
                        r_out_valid <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_busy      <= 1'b0;
                    r_p_ready   <= 1'b0;
                    r_out_valid <= 1'b0;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

    assign o_busy      = r_busy;
    assign o_p_ready   = r_p_ready;
    assign o_out_valid = r_out_valid;
    assign o_acc_out   = r_acc;
    assign o_ovf       = r_ovf;

endmodule

// File: tb/tb_dot_prod_accum.sv
// Directed bench for dot_prod_accum: a 12-bit and a 10-bit instance run the same stimulus.
`timescale 1ns/1ps
module tb_dot_prod_accum;

    localparam int LEN_W = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             i_start;
    logic [LEN_W-1:0] i_len;
    logic [7:0]       i_p_data;
    logic             i_p_valid;
    logic             i_out_ready;

    logic             busy12, p_ready12, out_valid12, ovf12;
    logic [11:0]      acc12;
    logic             busy10, p_ready10, out_valid10, ovf10;
    logic [9:0]       acc10;

    always #5 clk = ~clk;

    dot_prod_accum #(.ACC_W(12), .LEN_W(LEN_W)) u_dut (
        .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_len(i_len), .o_busy(busy12),
        .i_p_data(i_p_data), .i_p_valid(i_p_valid), .o_p_ready(p_ready12),
        .o_acc_out(acc12), .o_out_valid(out_valid12), .i_out_ready(i_out_ready), .o_ovf(ovf12)
    );

    dot_prod_accum #(.ACC_W(10), .LEN_W(LEN_W)) u_dut10 (
        .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_len(i_len), .o_busy(busy10),
        .i_p_data(i_p_data), .i_p_valid(i_p_valid), .o_p_ready(p_ready10),
        .o_acc_out(acc10), .o_out_valid(out_valid10), .i_out_ready(i_out_ready), .o_ovf(ovf10)
    );

    typedef struct {
        int a12;
        bit o12;
        int a10;
        bit o10;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   hs_cnt = 0;
    int   m12, m10, m_left;
    bit   v12, v10;
    int   last_a12;

    // Handshake monitor: inputs are stable around the falling edge.
    always @(negedge clk) begin
        if (i_p_valid && p_ready12) hs_cnt++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    function automatic void madd(input int w, input int d, inout int acc, inout bit ovf);
        int s;
        int lim;
        lim = (1 << w) - 1;
        s = acc + d;
        if (s > lim) begin
            ovf = 1'b1;
`ifdef DOT_PROD_SAT_EN
            acc = lim;
`else
            acc = s % (1 << w);
`endif
        end else begin
            acc = s;
        end
    endfunction

    task automatic push_expected();
        exp_t e;
        e.a12 = m12; e.o12 = v12; e.a10 = m10; e.o10 = v10;
        sb_q.push_back(e);
        $display("push expected acc12=%0d ovf12=%0d acc10=%0d ovf10=%0d", m12, v12, m10, v10);
    endtask

    task automatic start_run(input int len);
        i_start = 1'b1;
        i_len   = LEN_W'(len);
        m12 = 0; m10 = 0; v12 = 1'b0; v10 = 1'b0;
        m_left = len;
        if (len == 0) push_expected();
        @(posedge clk);
        #1;
        i_start = 1'b0;
        $display("start run len=%0d", len);
    endtask

    task automatic send(input int d, input int gap);
        bit ok;
        i_p_valid = 1'b0;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
        i_p_data  = 8'(d);
        i_p_valid = 1'b1;
        ok = 1'b0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (p_ready12) begin
                ok = 1'b1;
                break;
            end
        end
        chk("p_ready12", p_ready12, 1);
        chk("p_ready10", p_ready10, 1);
        chk("no_early_valid", out_valid12, 0);
        @(posedge clk);
        #1;
        i_p_valid = 1'b0;
        if (ok) begin
            madd(12, d, m12, v12);
            madd(10, d, m10, v10);
            m_left--;
            if (m_left == 0) push_expected();
            $display("accept product %0d", d);
        end
    endtask

    task automatic collect(input bit with_start);
        exp_t e;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (out_valid12) break;
        end
        chk("out_valid12", out_valid12, 1);
        chk("out_valid10", out_valid10, 1);
        chk("hold_p_ready", p_ready12, 0);
        chk("sb_nonempty", (sb_q.size() > 0) ? 1 : 0, 1);
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk("acc12", acc12, e.a12);
            chk("ovf12", ovf12, e.o12);
            chk("acc10", acc10, e.a10);
            chk("ovf10", ovf10, e.o10);
            last_a12 = e.a12;
            $display("result acc12=%0d ovf12=%0d acc10=%0d ovf10=%0d", acc12, ovf12, acc10, ovf10);
        end
        i_out_ready = 1'b1;
        i_start     = with_start;
        i_len       = LEN_W'(3);
        @(posedge clk);
        #1;
        i_out_ready = 1'b0;
        i_start     = 1'b0;
        @(negedge clk);
        chk("drop_valid", out_valid12, 0);
        chk("idle_busy12", busy12, 0);
        chk("idle_busy10", busy10, 0);
        chk("idle_retain", acc12, last_a12);
    endtask

    initial begin
        int base;
        exp_t pk;
        rst_n = 1'b0; i_start = 1'b0; i_len = '0; i_p_data = '0;
        i_p_valid = 1'b0; i_out_ready = 1'b0; last_a12 = 0;
        repeat (2) @(negedge clk);
        chk("rst_acc", acc12, 0);
        chk("rst_busy", busy12, 0);
        chk("rst_p_ready", p_ready12, 0);
        chk("rst_out_valid", out_valid12, 0);
        chk("rst_ovf", ovf12, 0);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // 1: basic run with p_valid held high
        start_run(3);
        chk("t1_busy", busy12, 1);
        chk("t1_p_ready", p_ready12, 1);
        for (int i = 0; i < 3; i++) send(225, 0);
        @(negedge clk);
        chk("t1_latency", out_valid12, 1);
        collect(0);

        // 2: input gaps, output backpressure, start ignored in HOLD
        start_run(4);
        send(6, 2); send(0, 2); send(15, 2); send(100, 2);
        pk = sb_q[0];
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t2_hold_acc", acc12, pk.a12);
            chk("t2_hold_valid", out_valid12, 1);
            i_start = (i == 2);
            i_len   = LEN_W'(5);
        end
        i_start = 1'b0;
        collect(1);
        @(negedge clk);
        chk("t2_start_ignored", busy12, 0);

        // 3: overflow on the 10-bit instance, then a clean run clears ovf
        start_run(5);
        for (int i = 0; i < 5; i++) send(225, 0);
        collect(0);
        start_run(1);
        send(7, 0);
        collect(0);

        // 4: empty run
        start_run(0);
        @(negedge clk);
        chk("t4_valid", out_valid12, 1);
        chk("t4_p_ready", p_ready12, 0);
        chk("t4_acc", acc12, 0);
        collect(0);

        // 5: asynchronous reset mid-run
        start_run(6);
        send(50, 0); send(50, 0);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("t5_acc12", acc12, 0);
        chk("t5_acc10", acc10, 0);
        chk("t5_busy", busy12, 0);
        chk("t5_p_ready", p_ready12, 0);
        chk("t5_out_valid", out_valid12, 0);
        chk("t5_ovf", ovf12, 0);
        $display("async reset applied mid-run");
        m_left = 0;
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        start_run(1);
        send(9, 0);
        collect(0);

        // 6: maximum length run, extra p_valid in HOLD must not be accepted
        base = hs_cnt;
        start_run(15);
        for (int i = 0; i < 15; i++) send(255, 0);
        i_p_valid = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        i_p_valid = 1'b0;
        chk("t6_handshakes", hs_cnt - base, 15);
        collect(0);

        chk("sb_drained", sb_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
